// File: rtl/stall_pkg.sv
// Shared types and default constants for the MIPS pipeline stall controller.
package stall_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam int DEF_CNT_W          = 32;
  localparam int DEF_WD_LIMIT       = 255;
  localparam int DEF_WD_W           = 8;
  localparam int DEF_MAX_DATA_STALL = 2;
endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/memory inputs and freeze/bubble/flush/status outputs of the stall controller.
interface pipeline_stall_controller_if #(parameter int CNT_W = 32);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_PC;
  logic             freeze_IF_ID;
  logic             bubble_ID_EXE;
  logic             flush_IF_ID;
  logic             freeze_back;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] mem_wait_cycles;
  logic             wd_error;
  logic             hazard_overrun;

  modport master (
    output hazard_detected, branch_taken, mem_req, mem_ready,
    input  freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_back,
    input  stall_cycles, flush_count, mem_wait_cycles, wd_error, hazard_overrun
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_req, mem_ready,
    output freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_back,
    output stall_cycles, flush_count, mem_wait_cycles, wd_error, hazard_overrun
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end
endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/bubble/flush control for a 5-stage MIPS pipeline without forwarding,
// with a memory-wait watchdog, data-stall overrun flag and perf counters.
module pipeline_stall_controller
  import stall_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int WD_LIMIT       = DEF_WD_LIMIT,
  parameter int WD_W           = DEF_WD_W,
  parameter int MAX_DATA_STALL = DEF_MAX_DATA_STALL
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_stall_controller_if.slave  bus
);
  localparam int DS_W = $clog2(MAX_DATA_STALL + 2);
  localparam logic [WD_W-1:0] WD_MAX  = WD_LIMIT[WD_W-1:0];
  localparam logic [WD_W-1:0] WD_LAST = WD_MAX - 1'b1;
  localparam logic [DS_W-1:0] DS_MAX  = MAX_DATA_STALL[DS_W-1:0];
  localparam logic [DS_W-1:0] DS_TOP  = DS_MAX + 1'b1;

  state_e          r_state;
  logic [WD_W-1:0] r_wd_cnt;
  logic [DS_W-1:0] r_ds_cnt;
  logic            r_wd_error;
  logic            r_overrun;
  logic            w_mem_stall;
  logic            w_hazard;
  logic            w_flush;

  // Combinational controls are forced low while reset is asserted.
  assign w_mem_stall = ~rst & (((r_state == RUN) & bus.mem_req & ~bus.mem_ready) |
                               ((r_state == MEM_WAIT) & ~bus.mem_ready));
  assign w_hazard    = ~rst & ~w_mem_stall & bus.hazard_detected;
  assign w_flush     = ~rst & ~w_mem_stall & ~bus.hazard_detected & bus.branch_taken;

  assign bus.freeze_PC      = w_mem_stall | w_hazard;
  assign bus.freeze_IF_ID   = w_mem_stall | w_hazard;
  assign bus.bubble_ID_EXE  = w_hazard;
  assign bus.flush_IF_ID    = w_flush;
  assign bus.freeze_back    = w_mem_stall;
  assign bus.wd_error       = r_wd_error;
  assign bus.hazard_overrun = r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:      if (bus.mem_req && !bus.mem_ready) r_state <= MEM_WAIT;
        MEM_WAIT: if (bus.mem_ready)                 r_state <= RUN;
        default:                                     r_state <= RUN;
      endcase
    end
  end

  // Watchdog trips on the edge that completes the WD_LIMIT-th consecutive stall cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt   <= '0;
      r_wd_error <= 1'b0;
    end else if (w_mem_stall) begin
      if (r_wd_cnt != WD_MAX)  r_wd_cnt   <= r_wd_cnt + 1'b1;
      if (r_wd_cnt >= WD_LAST) r_wd_error <= 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // A memory freeze pauses the data-stall run rather than ending it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ds_cnt  <= '0;
      r_overrun <= 1'b0;
    end else if (w_hazard) begin
      if (r_ds_cnt != DS_TOP)  r_ds_cnt  <= r_ds_cnt + 1'b1;
      if (r_ds_cnt >= DS_MAX)  r_overrun <= 1'b1;
    end else if (!w_mem_stall) begin
      r_ds_cnt <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(w_hazard), .count(bus.stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(w_flush), .count(bus.flush_count)
  );
  sat_counter #(.W(CNT_W)) u_memw_cnt (
    .clk(clk), .rst(rst), .inc(w_mem_stall), .count(bus.mem_wait_cycles)
  );
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Table vectors, directed corner sequences and random traffic against a cycle-level reference model.
module tb_pipeline_stall_controller;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int WDL   = 3;
  localparam int MDS   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus();

  pipeline_stall_controller #(
    .CNT_W(CNT_W), .WD_LIMIT(WDL), .WD_W(8), .MAX_DATA_STALL(MDS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit m_waiting, m_wd, m_ov;
  int m_wd_run, m_ds_run, m_stall, m_flush, m_memw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic drive(input bit h, input bit b, input bit mr, input bit rdy);
    bus.hazard_detected = h;
    bus.branch_taken    = b;
    bus.mem_req         = mr;
    bus.mem_ready       = rdy;
  endtask

  task automatic chk_all_zero();
    chk("rst_freeze_PC",    bus.freeze_PC, 0);
    chk("rst_freeze_IF_ID", bus.freeze_IF_ID, 0);
    chk("rst_bubble",       bus.bubble_ID_EXE, 0);
    chk("rst_flush",        bus.flush_IF_ID, 0);
    chk("rst_freeze_back",  bus.freeze_back, 0);
    chk("rst_stall_cycles", bus.stall_cycles, 0);
    chk("rst_flush_count",  bus.flush_count, 0);
    chk("rst_mem_wait",     bus.mem_wait_cycles, 0);
    chk("rst_wd_error",     bus.wd_error, 0);
    chk("rst_overrun",      bus.hazard_overrun, 0);
  endtask

  // Entered and left at posedge+1; rst is raised mid-cycle with current inputs still driven.
  task automatic do_reset();
    #1 rst = 1'b1;
    #2 chk_all_zero();
    m_waiting = 0; m_wd = 0; m_ov = 0;
    m_wd_run = 0; m_ds_run = 0; m_stall = 0; m_flush = 0; m_memw = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(input bit h, input bit b, input bit mr, input bit rdy);
    bit ms, bub, fl;
    drive(h, b, mr, rdy);
    #2;
    ms  = m_waiting ? !rdy : (mr && !rdy);
    bub = !ms && h;
    fl  = !ms && !h && b;
    chk("freeze_PC",       bus.freeze_PC, ms || h);
    chk("freeze_IF_ID",    bus.freeze_IF_ID, ms || h);
    chk("bubble_ID_EXE",   bus.bubble_ID_EXE, bub);
    chk("flush_IF_ID",     bus.flush_IF_ID, fl);
    chk("freeze_back",     bus.freeze_back, ms);
    chk("stall_cycles",    bus.stall_cycles, m_stall);
    chk("flush_count",     bus.flush_count, m_flush);
    chk("mem_wait_cycles", bus.mem_wait_cycles, m_memw);
    chk("wd_error",        bus.wd_error, m_wd);
    chk("hazard_overrun",  bus.hazard_overrun, m_ov);
    @(posedge clk);
    m_wd_run = ms ? m_wd_run + 1 : 0;
    if (m_wd_run >= WDL) m_wd = 1;
    if (bub)      m_ds_run++;
    else if (!ms) m_ds_run = 0;
    if (m_ds_run > MDS) m_ov = 1;
    if (bub) m_stall = sat(m_stall);
    if (fl)  m_flush = sat(m_flush);
    if (ms)  m_memw  = sat(m_memw);
    m_waiting = m_waiting ? !rdy : (mr && !rdy);
    #1;
  endtask

  typedef struct {
    bit h, b, mr, rdy;
    bit fpc, fif, bub, fl, fb;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // single cycles from RUN: {h,b,mr,rdy} -> {freeze_PC,freeze_IF_ID,bubble,flush,freeze_back}
    tbl[0] = '{0,0,0,0, 0,0,0,0,0};
    tbl[1] = '{0,1,0,0, 0,0,0,1,0};
    tbl[2] = '{1,0,0,0, 1,1,1,0,0};
    tbl[3] = '{1,1,0,0, 1,1,1,0,0};
    tbl[4] = '{0,0,1,0, 1,1,0,0,1};
    tbl[5] = '{1,1,1,0, 1,1,0,0,1};
    tbl[6] = '{0,0,1,1, 0,0,0,0,0};
    tbl[7] = '{1,0,1,1, 1,1,1,0,0};
    tbl[8] = '{0,1,1,1, 0,0,0,1,0};

    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive(tbl[i].h, tbl[i].b, tbl[i].mr, tbl[i].rdy);
      #2;
      chk("tbl_freeze_PC",    bus.freeze_PC, tbl[i].fpc);
      chk("tbl_freeze_IF_ID", bus.freeze_IF_ID, tbl[i].fif);
      chk("tbl_bubble",       bus.bubble_ID_EXE, tbl[i].bub);
      chk("tbl_flush",        bus.flush_IF_ID, tbl[i].fl);
      chk("tbl_freeze_back",  bus.freeze_back, tbl[i].fb);
      @(posedge clk); #1;
      chk("tbl_stall_cycles", bus.stall_cycles, tbl[i].bub);
      chk("tbl_flush_count",  bus.flush_count, tbl[i].fl);
      chk("tbl_mem_wait",     bus.mem_wait_cycles, tbl[i].fb);
    end

    // reset in the middle of a memory wait
    do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    drive(1, 1, 1, 0);
    do_reset();
    drive(0, 0, 0, 0);
    #2 chk("post_rst_run_no_freeze", bus.freeze_back, 0);
    step(0, 0, 0, 0);

    // data hazard: two cycles then a third
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("ds2_stall_cycles", bus.stall_cycles, 2);
    chk("ds2_overrun",      bus.hazard_overrun, 0);
    step(1, 0, 0, 0);
    chk("ds3_overrun",      bus.hazard_overrun, 1);
    step(0, 0, 0, 0);
    chk("ds_overrun_sticky", bus.hazard_overrun, 1);

    // hazard and branch together
    do_reset();
    step(1, 1, 0, 0);
    chk("hb_flush_count",  bus.flush_count, 0);
    chk("hb_stall_cycles", bus.stall_cycles, 1);

    // four-cycle memory wait
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("mw_mem_wait_cycles", bus.mem_wait_cycles, 4);
    drive(0, 0, 0, 0);
    #2 chk("mw_back_to_run", bus.freeze_back, 0);
    step(0, 0, 0, 0);

    // memory + hazard + branch at once
    do_reset();
    step(1, 1, 1, 0);
    chk("all_stall_cycles", bus.stall_cycles, 0);
    chk("all_flush_count",  bus.flush_count, 0);
    chk("all_mem_wait",     bus.mem_wait_cycles, 1);
    step(1, 1, 0, 0);

    // watchdog with limit 3
    do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("wd_after2", bus.wd_error, 0);
    step(0, 0, 0, 0);
    chk("wd_after3", bus.wd_error, 1);
    step(0, 0, 0, 1);
    chk("wd_sticky", bus.wd_error, 1);

    // counter saturation
    do_reset();
    for (int i = 0; i < CMAX + 3; i++) step(0, 1, 0, 0);
    chk("sat_flush_count", bus.flush_count, CMAX);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
